// File: rtl/mul_unit.sv
// Sequential shift-add multiplier for mult/multu; full product lands in HI/LO after WIDTH cycles.
// Optional macro MUL_SIGNED_EN adds signed_op and a FIX cycle that applies the product sign.
module mul_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef MUL_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             lohi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

`ifdef MUL_SIGNED_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

   state_t               state_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   acc_next_s;
   logic [WIDTH-1:0]     mcand_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [WIDTH:0]       sum_s;
   logic                 sop_s;
`ifdef MUL_SIGNED_EN
   logic                 neg_r;
   logic [2*WIDTH-1:0]   fixed_s;

   assign sop_s = signed_op;
`else
   assign sop_s = 1'b0;
`endif

   // Two's-complement magnitude of an operand when a signed operation is requested.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
      if (en && v[WIDTH-1]) begin
         return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // One shift-add step: carry of the upper-half add is shifted back into the product.
   always_comb begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      if (acc_r[0]) begin
         sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
      end else begin
         sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
   end

`ifdef MUL_SIGNED_EN
   // Sign correction of the unsigned product for the FIX cycle.
   always_comb begin
      fixed_s = acc_r;
      if (neg_r) begin
         fixed_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         fixed_s = acc_r;
      end
   end
`endif

   // Control FSM with datapath registers; HI/LO only change on the commit edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         acc_r   <= '0;
         mcand_r <= '0;
         cnt_r   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MUL_SIGNED_EN
         neg_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand_r <= magnitude(a, sop_s);
                  acc_r   <= {{WIDTH{1'b0}}, magnitude(b, sop_s)};
                  cnt_r   <= '0;
                  busy    <= 1'b1;
                  state_r <= RUN;
`ifdef MUL_SIGNED_EN
                  neg_r   <= sop_s & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
               end
            end
            RUN: begin
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_W'(WIDTH-1)) begin
`ifdef MUL_SIGNED_EN
                  state_r <= FIX;
`else
                  hi      <= acc_next_s[2*WIDTH-1:WIDTH];
                  lo      <= acc_next_s[WIDTH-1:0];
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
`endif
               end
            end
`ifdef MUL_SIGNED_EN
            FIX: begin
               hi      <= fixed_s[2*WIDTH-1:WIDTH];
               lo      <= fixed_s[WIDTH-1:0];
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
`endif
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   assign result = lohi ? hi : lo;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: table-driven products plus hand-written
// sequences for ignored start, back-to-back start and mid-operation reset.
module tb_mul_unit;
   localparam int W = 32;
`ifdef MUL_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         lohi = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo, result;
`ifdef MUL_SIGNED_EN
   logic         signed_op = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         sgn;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   vec_t vecs[$];

   mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef MUL_SIGNED_EN
      .signed_op(signed_op),
`endif
      .a(a), .b(b), .lohi(lohi),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present operands for one cycle, then scramble them to prove they were latched.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
`ifdef MUL_SIGNED_EN
      signed_op = s;
`else
      if (s) $display("note: signed vector issued in unsigned build");
`endif
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = ~bv;
   endtask

   // Counts edges after the start edge until done; flags any HI/LO change or busy drop before it.
   task automatic wait_done(input logic [W-1:0] old_hi, input logic [W-1:0] old_lo,
                            output int lat, output bit held, output bit busy_ok);
      lat = 0; held = 1'b1; busy_ok = 1'b1;
      while (!done && lat < 200) begin
         if (hi !== old_hi || lo !== old_lo) held = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [W-1:0] oh, ol;
      int lat;
      bit held, bok;
      oh = hi; ol = lo;
      issue(v.va, v.vb, v.sgn);
      check($sformatf("busy_after_start[%0d]", idx), busy, 1'b1);
      wait_done(oh, ol, lat, held, bok);
      check($sformatf("latency[%0d]", idx), lat, LAT);
      check($sformatf("hilo_held[%0d]", idx), held, 1'b1);
      check($sformatf("busy_during_run[%0d]", idx), bok, 1'b1);
      check($sformatf("busy_at_done[%0d]", idx), busy, 1'b0);
      check($sformatf("hi[%0d]", idx), hi, v.exp_hi);
      check($sformatf("lo[%0d]", idx), lo, v.exp_lo);
      lohi = 1'b0; #1;
      check($sformatf("result_lo[%0d]", idx), result, v.exp_lo);
      lohi = 1'b1; #1;
      check($sformatf("result_hi[%0d]", idx), result, v.exp_hi);
      lohi = 1'b0;
      @(negedge clk);
      check($sformatf("done_pulse_end[%0d]", idx), done, 1'b0);
   endtask

   initial begin
      int dcount, dlat, lat;
      bit held, bok;

      vecs.push_back('{32'd3,          32'd5,          1'b0, 32'h0000_0000, 32'h0000_000F});
      vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{32'h0001_0000,  32'h0001_0000,  1'b0, 32'h0000_0001, 32'h0000_0000});
      vecs.push_back('{32'h0000_0000,  32'hDEAD_BEEF,  1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32'h0000_0000, 32'hFFFF_FFFF});
      vecs.push_back('{32'h0000_FFFF,  32'h0000_FFFF,  1'b0, 32'h0000_0000, 32'hFFFE_0001});
      vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b0, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{32'h8000_0000,  32'h0000_0002,  1'b0, 32'h0000_0001, 32'h0000_0000});
`ifdef MUL_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFFF,  32'd5,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB});
      vecs.push_back('{32'hFFFF_FFFF,  32'd5,          1'b0, 32'h0000_0004, 32'hFFFF_FFFB});
      vecs.push_back('{32'hFFFF_FFFD,  32'hFFFF_FFFC,  1'b1, 32'h0000_0000, 32'h0000_000C});
      vecs.push_back('{32'h8000_0000,  32'h0000_0001,  1'b1, 32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{32'd7,          32'hFFFF_FFF7,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFC1});
`endif

      // Reset held low for two cycles, then released.
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      lohi = 1'b0; #1;
      check("reset_result_lo", result, 32'h0);
      lohi = 1'b1; #1;
      check("reset_result_hi", result, 32'h0);
      lohi = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // start pulsed mid-operation must be ignored.
      issue(32'd7, 32'd9, 1'b0);
      dcount = 0; dlat = 0;
      for (int c = 1; c <= LAT; c++) begin
         start = (c == 5 || c == 20);
         a = 32'd100; b = 32'd100;
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dcount++;
            dlat = c;
         end
      end
      check("ignore_done_count", dcount, 1);
      check("ignore_latency", dlat, LAT);
      check("ignore_lo", lo, 32'd63);
      check("ignore_hi", hi, 32'd0);

      // Back-to-back: start in the done cycle is accepted.
      a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
`ifdef MUL_SIGNED_EN
      signed_op = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      check("b2b_done_drop", done, 1'b0);
      check("b2b_busy", busy, 1'b1);
      wait_done(32'h0, 32'd63, lat, held, bok);
      check("b2b_latency", lat, LAT);
      check("b2b_held", held, 1'b1);
      check("b2b_hi", hi, 32'h1);
      check("b2b_lo", lo, 32'h0);

      // Asynchronous reset mid-operation aborts without a partial result.
      issue(32'h1234, 32'h5678, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      dcount = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      check("abort_no_activity", dcount, 0);
      run_vec('{32'd2, 32'd2, 1'b0, 32'h0, 32'h4}, 99);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
